pipe_hazard_scoreboard: RTL

Parametrised decode-stage hazard block for the pipelined CPU. It resolves operand forwarding from the EX and MEM stages and detects load-use interlocks. It adds a scoreboard for one multi-cycle execution unit (mul/div) of configurable latency, which the earlier single-cycle decode logic could not handle. It sits between the register file read ports and the ID/EX pipeline register, and drives the PC/IR write-enable.

---
 rtl/pipe_hazard_scoreboard.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_scoreboard.sv
// Decode-stage hazard unit: EX/MEM forwarding, load-use interlock, mul/div scoreboard.
// Define HAZ_STATS_EN to add the saturating stall_cnt output.
module pipe_hazard_scoreboard #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int MDLAT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_is_md,
    input  logic [XLEN-1:0] qa,
    input  logic [XLEN-1:0] qb,
    input  logic            e_wreg,
    input  logic            e_m2reg,
    input  logic [AW-1:0]   e_rn,
    input  logic [XLEN-1:0] e_alu,
    input  logic            m_wreg,
    input  logic            m_m2reg,
    input  logic [AW-1:0]   m_rn,
    input  logic [XLEN-1:0] m_alu,
    input  logic [XLEN-1:0] m_mo,
    output logic [XLEN-1:0] da,
    output logic [XLEN-1:0] db,
    output logic [1:0]      fwda,
    output logic [1:0]      fwdb,
    output logic            stall,
    output logic            md_busy,
    output logic [AW-1:0]   md_rn,
    output logic            md_done
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int CW = $clog2(MDLAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDLAT - 1);

    logic            md_busy_q, md_busy_d;
    logic [AW-1:0]   md_rn_q, md_rn_d;
    logic [CW-1:0]   md_cnt_q, md_cnt_d;
    logic            md_done_q, md_done_d;

    logic lu, raw, st, issue;

    // EX beats MEM; within MEM a load selects the memory data.
    always_comb begin
        fwda = 2'd0;
        if (id_rs != '0) begin
            if (e_wreg && !e_m2reg && e_rn == id_rs)
                fwda = 2'd1;
            else if (m_wreg && m_m2reg && m_rn == id_rs)
                fwda = 2'd3;
            else if (m_wreg && !m_m2reg && m_rn == id_rs)
                fwda = 2'd2;
        end
    end

    always_comb begin
        fwdb = 2'd0;
        if (id_rt != '0) begin
            if (e_wreg && !e_m2reg && e_rn == id_rt)
                fwdb = 2'd1;
            else if (m_wreg && m_m2reg && m_rn == id_rt)
                fwdb = 2'd3;
            else if (m_wreg && !m_m2reg && m_rn == id_rt)
                fwdb = 2'd2;
        end
    end

    always_comb begin
        da = qa;
        unique case (fwda)
            2'd0: da = qa;
            2'd1: da = e_alu;
            2'd2: da = m_alu;
            2'd3: da = m_mo;
        endcase
    end

    always_comb begin
        db = qb;
        unique case (fwdb)
            2'd0: db = qb;
            2'd1: db = e_alu;
            2'd2: db = m_alu;
            2'd3: db = m_mo;
        endcase
    end

    always_comb begin
        lu = e_wreg && e_m2reg && (e_rn != '0) &&
             ((id_use_rs && e_rn == id_rs) ||
              (id_use_rt && e_rn == id_rt));
        raw = md_busy_q && (md_rn_q != '0) &&
              ((id_use_rs && md_rn_q == id_rs) ||
               (id_use_rt && md_rn_q == id_rt) ||
               (id_wr && id_rd == md_rn_q));
        st = md_busy_q && id_is_md;
        stall = id_valid && (lu || raw || st);
        issue = id_valid && id_is_md && !stall;
    end

    // Counter keeps running through decode stalls; it is only loaded while idle.
    always_comb begin
        md_busy_d = md_busy_q;
        md_rn_d   = md_rn_q;
        md_cnt_d  = md_cnt_q;
        md_done_d = 1'b0;
        if (md_busy_q) begin
            if (md_cnt_q == '0) begin
                md_busy_d = 1'b0;
                md_done_d = 1'b1;
            end else begin
                md_cnt_d = md_cnt_q - CW'(1);
            end
        end else if (issue) begin
            md_busy_d = 1'b1;
            md_rn_d   = id_rd;
            md_cnt_d  = CNT_LOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_busy_q <= 1'b0;
            md_rn_q   <= '0;
            md_cnt_q  <= '0;
            md_done_q <= 1'b0;
        end else begin
            md_busy_q <= md_busy_d;
            md_rn_q   <= md_rn_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_busy = md_busy_q;
    assign md_rn   = md_rn_q;
    assign md_done = md_done_q;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
